dfifo32_sync: RTL and testbench
===============================

// Module: dfifo32_sync
// PURPOSE
//  Single-clock synchronous FIFO, 16 x 32 bit, with registered read data and
//  full/empty/almost flags. Used as a rate-decoupling buffer inside the DDR3
//  controller datapath. Writer and reader share one clock domain.
// PARAMETERS
//  ADDR_WIDTH        4     log2 depth; DEPTH = 2**ADDR_WIDTH = 16 entries
//  DATA_WIDTH        32    word width
//  OUT_REG           1     1: extra output register on rd_data; 0: none
//  ALMOST_FULL_NUM   14    almost_full when count >= this value
//  ALMOST_EMPTY_NUM  4     almost_empty when count <= this value
// PORTS
//  clk           in   1          clock, all logic on rising edge
//  rst           in   1          reset, synchronous, active-high
//  wr_data       in   DATA_WIDTH write word
//  wr_en         in   1          write request
//  full          out  1          count == DEPTH
//  almost_full   out  1          count >= ALMOST_FULL_NUM
//  rd_en         in   1          read request
//  rd_data       out  DATA_WIDTH read word (registered)
//  empty         out  1          count == 0
//  almost_empty  out  1          count <= ALMOST_EMPTY_NUM
// BEHAVIOUR
//  - Reset (rst=1 at a rising edge): wr_ptr=rd_ptr=0, count=0, empty=1,
//    almost_empty=1, full=0, almost_full=0, rd_data=0, read pipeline cleared.
//    Reset mid-operation discards all stored data. RAM contents are not cleared.
//  - Write accepted = wr_en & !full: mem[wr_ptr] <= wr_data, wr_ptr+1.
//    Write while full is ignored; no overflow, data and pointers unchanged.
//  - Read accepted = rd_en & !empty: rd_ptr+1.
//    Read while empty is ignored; rd_data holds its value.
//  - Pointers are ADDR_WIDTH bits and wrap modulo DEPTH (15 -> 0).
//  - count is ADDR_WIDTH+1 bits:
//    +1 on write only, -1 on read only, unchanged on both/neither.
//  - Simultaneous accepted read and write: both are performed.
//    When empty, only the write is accepted; when full, only the read.
//    No first-word fall-through: a word written at edge k is readable from edge k+1.
//  - Flags are registered. They are computed from the next count and update
//    on the same edge as the accepted operation.
//  - Read latency, OUT_REG=1: a read accepted at edge k loads mem[rd_ptr] into
//    a read stage. The output register presents that word after edge k+1.
//  - Read latency, OUT_REG=0: the word is presented after edge k.
//  - rd_data changes only when a read propagates through the pipeline;
//    otherwise it holds its last value.
// STRUCTURE
//  - Shared package dfifo32_pkg: DEPTH, ADDR_WIDTH and DATA_WIDTH defaults,
//    and the flag threshold constants.
//  - One sub-module, dfifo32_ram: simple dual-port RAM, DEPTH x DATA_WIDTH,
//    with a synchronous write port and a synchronous registered read port.
//  - Top level holds the pointers, count, flag registers and optional output register.
//  - Device global-reset primitives are instantiated by the bench/top, not here.
// TESTING
//  1 Reset: rst high 20 cycles -> empty=1, almost_empty=1, full=0,
//    almost_full=0, rd_data=0.
//  2 Fill: write 1..16 on consecutive cycles ->
//    almost_empty falls when count reaches 5; almost_full rises at count 14;
//    full rises at count 16; a 17th write (value 99) is ignored.
//  3 Drain: hold rd_en 16 cycles -> rd_data = 1,2,...,16 in order with
//    2-edge latency (OUT_REG=1); empty=1 after the 16th read;
//    an extra read leaves rd_data=16.
//  4 Wrap: write 10, read 10, write 16, read 16 ->
//    data in order across the pointer wrap; no loss or duplication.
//  5 Simultaneous: at count=8, wr_en=rd_en=1 for 20 cycles ->
//    count stays 8; output stream is in order.
//  6 Mid-reset: write 6 words, assert rst one cycle ->
//    empty=1, count 0, and the next read returns only newly written data.

Source files
------------

// File: rtl/dfifo32_pkg.sv
// dfifo32_pkg
//  Shared constants for the 16 x 32 synchronous FIFO: default geometry,
//  flag thresholds, the registered flag bundle and the flag computation
//  used by the top level.
package dfifo32_pkg;

  localparam int FIFO_ADDR_WIDTH       = 4;
  localparam int FIFO_DATA_WIDTH       = 32;
  localparam int FIFO_DEPTH            = 1 << FIFO_ADDR_WIDTH;
  localparam int FIFO_ALMOST_FULL_NUM  = 14;
  localparam int FIFO_ALMOST_EMPTY_NUM = 4;

  typedef struct packed {
    logic empty;
    logic almost_empty;
    logic full;
    logic almost_full;
  } fifo_flags_t;

  // Flags for a given occupancy; the caller passes the count that will be
  // valid after the current edge so the flag registers stay cycle-exact.
  function automatic fifo_flags_t fifo_flags(input int count, input int depth,
                                             input int af_num, input int ae_num);
    fifo_flags_t f;
    f.empty        = (count == 0);
    f.almost_empty = (count <= ae_num);
    f.full         = (count == depth);
    f.almost_full  = (count >= af_num);
    return f;
  endfunction

endpackage

// File: rtl/dfifo32_ram.sv
// dfifo32_ram
//  Simple dual-port RAM, DEPTH x DATA_WIDTH, one synchronous write port and
//  one synchronous read port with a registered output.
// Ports
//  clk      in   clock
//  rst      in   synchronous active-high reset, clears the read register only
//  wr_en    in   write strobe
//  wr_addr  in   write address
//  wr_data  in   write word
//  rd_en    in   read strobe, loads the read register
//  rd_addr  in   read address
//  rd_data  out  registered read word, holds when rd_en is low
module dfifo32_ram
  import dfifo32_pkg::*;
#(
  parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH,
  parameter int DATA_WIDTH = FIFO_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Storage array carries no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst)        rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/dfifo32_sync.sv
// dfifo32_sync
//  Single-clock FIFO, 16 x 32 by default, registered read data and
//  registered full/empty/almost flags. Rate-decoupling buffer for the DDR3
//  controller datapath.
// Ports
//  clk           in   clock, rising edge
//  rst           in   synchronous active-high reset
//  wr_data       in   write word
//  wr_en         in   write request, ignored while full
//  full          out  count == DEPTH
//  almost_full   out  count >= ALMOST_FULL_NUM
//  rd_en         in   read request, ignored while empty
//  rd_data       out  read word, holds between reads
//  empty         out  count == 0
//  almost_empty  out  count <= ALMOST_EMPTY_NUM
module dfifo32_sync
  import dfifo32_pkg::*;
#(
  parameter int ADDR_WIDTH       = FIFO_ADDR_WIDTH,
  parameter int DATA_WIDTH       = FIFO_DATA_WIDTH,
  parameter int OUT_REG          = 1,
  parameter int ALMOST_FULL_NUM  = FIFO_ALMOST_FULL_NUM,
  parameter int ALMOST_EMPTY_NUM = FIFO_ALMOST_EMPTY_NUM
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_en,
  output logic                  full,
  output logic                  almost_full,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  empty,
  output logic                  almost_empty
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   count;
  logic [ADDR_WIDTH:0]   count_nxt;
  logic                  wr_acc;
  logic                  rd_acc;
  logic [DATA_WIDTH-1:0] rd_data_p1;
  fifo_flags_t           flags_nxt;

  function automatic logic [ADDR_WIDTH:0] count_next(input logic [ADDR_WIDTH:0] c,
                                                     input logic w, input logic r);
    case ({w, r})
      2'b10:   return c + (ADDR_WIDTH+1)'(1);
      2'b01:   return c - (ADDR_WIDTH+1)'(1);
      default: return c;
    endcase
  endfunction

  // ---- stage p0: accept requests against the registered flags ----
  // Gating by the registered flags means a read while empty can never pick up
  // a word written on the same edge, and a write while full never overwrites
  // the word under rd_ptr.
  assign wr_acc    = wr_en & ~full;
  assign rd_acc    = rd_en & ~empty;
  assign count_nxt = count_next(count, wr_acc, rd_acc);
  assign flags_nxt = fifo_flags(int'(count_nxt), DEPTH, ALMOST_FULL_NUM, ALMOST_EMPTY_NUM);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      empty        <= 1'b1;
      almost_empty <= 1'b1;
      full         <= 1'b0;
      almost_full  <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
      if (rd_acc) rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
      count        <= count_nxt;
      empty        <= flags_nxt.empty;
      almost_empty <= flags_nxt.almost_empty;
      full         <= flags_nxt.full;
      almost_full  <= flags_nxt.almost_full;
    end
  end

  // ---- stage p1: RAM read register ----
  dfifo32_ram #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_acc),
    .wr_addr (wr_ptr),
    .wr_data (wr_data),
    .rd_en   (rd_acc),
    .rd_addr (rd_ptr),
    .rd_data (rd_data_p1)
  );

  // ---- stage p2: optional output register ----
  if (OUT_REG != 0) begin : g_out_reg
    logic                  vld_p1;
    logic [DATA_WIDTH-1:0] rd_data_p2;

    always_ff @(posedge clk) begin
      if (rst) vld_p1 <= 1'b0;
      else     vld_p1 <= rd_acc;
    end

    // Loads only when a read has reached the RAM register, so the output
    // holds its last word between reads.
    always_ff @(posedge clk) begin
      if (rst)         rd_data_p2 <= '0;
      else if (vld_p1) rd_data_p2 <= rd_data_p1;
    end

    assign rd_data = rd_data_p2;
  end else begin : g_no_out_reg
    assign rd_data = rd_data_p1;
  end

endmodule

// File: tb/tb_dfifo32_sync.sv
// tb_dfifo32_sync
//  Self-checking bench for dfifo32_sync (default parameters, OUT_REG=1).
//  A reference FIFO model predicts flags every cycle; read words are pushed
//  to a scoreboard queue on acceptance and popped when the two-edge read
//  latency has elapsed.
module tb_dfifo32_sync;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] wr_data;
  logic        wr_en;
  logic        full;
  logic        almost_full;
  logic        rd_en;
  logic [31:0] rd_data;
  logic        empty;
  logic        almost_empty;

  int errors = 0;
  int checks = 0;

  logic [31:0] mq[$];   // model FIFO contents
  logic [31:0] sb[$];   // scoreboard: words read, awaiting output
  logic        rd_vld_m;
  logic [31:0] exp_rd;

  typedef struct {
    logic        we;
    logic [31:0] wd;
    logic        re;
    logic        e_empty;
    logic        e_ae;
    logic        e_full;
    logic        e_af;
  } vec_t;

  vec_t vt[17];

  always #5 clk = ~clk;

  dfifo32_sync dut (
    .clk          (clk),
    .rst          (rst),
    .wr_data      (wr_data),
    .wr_en        (wr_en),
    .full         (full),
    .almost_full  (almost_full),
    .rd_en        (rd_en),
    .rd_data      (rd_data),
    .empty        (empty),
    .almost_empty (almost_empty)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_state();
    int n;
    n = mq.size();
    chk("empty",        {31'd0, empty},        {31'd0, n == 0});
    chk("almost_empty", {31'd0, almost_empty}, {31'd0, n <= 4});
    chk("full",         {31'd0, full},         {31'd0, n == 16});
    chk("almost_full",  {31'd0, almost_full},  {31'd0, n >= 14});
    chk("rd_data",      rd_data,               exp_rd);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; wr_data = '0;
    repeat (n) @(posedge clk);
    #1;
    mq.delete(); sb.delete(); rd_vld_m = 1'b0; exp_rd = '0;
    check_state();
    rst = 1'b0;
  endtask

  // One clock with the given inputs; model updated, outputs checked #1 after.
  task automatic cycle(input logic we, input logic [31:0] wd, input logic re);
    bit          wacc, racc, out_vld;
    logic [31:0] v;
    wr_en = we; wr_data = wd; rd_en = re;
    wacc = we && (mq.size() != 16);
    racc = re && (mq.size() != 0);
    @(posedge clk);
    if (racc) begin v = mq.pop_front(); sb.push_back(v); end
    if (wacc) mq.push_back(wd);
    out_vld  = rd_vld_m;
    rd_vld_m = racc;
    if (out_vld) exp_rd = sb.pop_front();
    #1;
    check_state();
    wr_en = 1'b0; rd_en = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Fill table: writes 1..16 then a rejected 17th write of 99.
    for (int i = 0; i < 17; i++) begin
      int c;
      c = (i < 16) ? i + 1 : 16;
      vt[i].we      = 1'b1;
      vt[i].wd      = (i < 16) ? 32'(i + 1) : 32'd99;
      vt[i].re      = 1'b0;
      vt[i].e_empty = 1'b0;
      vt[i].e_ae    = (c <= 4);
      vt[i].e_full  = (c == 16);
      vt[i].e_af    = (c >= 14);
    end

    rd_vld_m = 1'b0; exp_rd = '0;

    // 1 Reset
    do_reset(20);
    chk("reset_rd_data", rd_data, 32'd0);

    // 2 Fill
    for (int i = 0; i < 17; i++) begin
      cycle(vt[i].we, vt[i].wd, vt[i].re);
      chk("tbl_empty", {31'd0, empty},        {31'd0, vt[i].e_empty});
      chk("tbl_ae",    {31'd0, almost_empty}, {31'd0, vt[i].e_ae});
      chk("tbl_full",  {31'd0, full},         {31'd0, vt[i].e_full});
      chk("tbl_af",    {31'd0, almost_full},  {31'd0, vt[i].e_af});
    end

    // 3 Drain, then one extra read and idle cycles
    for (int i = 0; i < 16; i++) cycle(1'b0, '0, 1'b1);
    chk("drain_empty", {31'd0, empty}, 32'd1);
    cycle(1'b0, '0, 1'b1);
    cycle(1'b0, '0, 1'b0);
    cycle(1'b0, '0, 1'b0);
    chk("drain_last", rd_data, 32'd16);

    // 4 Wrap
    for (int i = 0; i < 10; i++) cycle(1'b1, 32'h100 + 32'(i), 1'b0);
    for (int i = 0; i < 10; i++) cycle(1'b0, '0, 1'b1);
    for (int i = 0; i < 16; i++) cycle(1'b1, 32'h200 + 32'(i), 1'b0);
    for (int i = 0; i < 16; i++) cycle(1'b0, '0, 1'b1);
    cycle(1'b0, '0, 1'b0);
    cycle(1'b0, '0, 1'b0);
    chk("wrap_last", rd_data, 32'h20F);
    chk("wrap_sb_empty", 32'(sb.size()), 32'd0);

    // 5 Simultaneous read/write at count 8
    for (int i = 0; i < 8; i++) cycle(1'b1, 32'h300 + 32'(i), 1'b0);
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, 32'h400 + 32'(i), 1'b1);
      chk("simul_flags", {28'd0, empty, almost_empty, full, almost_full}, 32'd0);
    end
    for (int i = 0; i < 8; i++) cycle(1'b0, '0, 1'b1);
    cycle(1'b0, '0, 1'b0);
    cycle(1'b0, '0, 1'b0);
    chk("simul_last", rd_data, 32'h413);
    chk("simul_empty", {31'd0, empty}, 32'd1);

    // Read while empty: ignored, rd_data holds
    cycle(1'b0, '0, 1'b1);
    cycle(1'b0, '0, 1'b0);
    chk("empty_read_hold", rd_data, 32'h413);

    // 6 Mid-reset
    for (int i = 0; i < 6; i++) cycle(1'b1, 32'h500 + 32'(i), 1'b0);
    do_reset(1);
    chk("midrst_empty", {31'd0, empty}, 32'd1);
    chk("midrst_rd_data", rd_data, 32'd0);
    cycle(1'b1, 32'hA5A5_0001, 1'b0);
    cycle(1'b0, '0, 1'b1);
    cycle(1'b0, '0, 1'b0);
    cycle(1'b0, '0, 1'b0);
    chk("midrst_new", rd_data, 32'hA5A5_0001);
    chk("midrst_empty2", {31'd0, empty}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
